multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle control unit for the processor datapath. It decodes the latched instruction and sequences IF → DEC → EXEC → MEM → WB over 3–5 cycles per instruction. It drives the ALU stage's `ALU_Bin_sel`/`ALU_func`, the PC, IR, register-file and data-memory enables, and the immediate-extension mode. All outputs are Moore outputs of the registered state plus the latched opcode and function fields.

## Interface
- `DATA_W`, 32, instruction width
- `Clk`  in  1  system clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `Instr`  in  32  IR contents: opcode `Instr[31:26]`, func `Instr[3:0]`; stable from DECODE until the next FETCH
- `ALU_zero`  in  1  ALU result == 0 in the current cycle
- `PC_sel`  out  1  0 = PC+4, 1 = PC + ImmExt (PC already incremented)
- `PC_LdEn`  out  1  PC write enable
- `Instr_LdEn`  out  1  IR write enable
- `RF_WrEn`  out  1  register-file write enable
- `RF_WrData_sel`  out  1  0 = ALU result register, 1 = memory data register
- `RF_B_sel`  out  1  0 = rt `Instr[15:11]`, 1 = rd `Instr[20:16]` as read port B address
- `ImmExt`  out  2  00 zero-ext, 01 sign-ext, 10 `<<16` zero-fill, 11 sign-ext `<<2`
- `ALU_Bin_sel`  out  1  0 = RF_B, 1 = Immed
- `ALU_func`  out  4  ALU operation code
- `MEM_WrEn`  out  1  data-memory write enable
- `ByteOp`  out  1  1 = byte access (`lb`/`sb`)

## Operation
- Opcodes:
  - `100000` R-type
  - `111000` li (rs=R0, sign-ext add)
  - `111001` lui
  - `110000` addi
  - `110010` andi
  - `110011` ori
  - `111111` b
  - `000000` beq
  - `000001` bne
  - `000011` lb
  - `000111` sb
  - `001111` lw
  - `011111` sw
- ALU_func codes:
  - `0000` add, `0001` sub, `0010` and, `0011` or, `0100` not A
  - `1000` sra, `1001` srl, `1010` sll, `1100` rol, `1101` ror
- R-type passes `Instr[3:0]` to `ALU_func`; I-type arithmetic uses add/and/or.
- States and transitions:
  - FETCH: `Instr_LdEn`=1, `PC_LdEn`=1, `PC_sel`=0 → DECODE.
  - DECODE: no enables. R-type → EXEC_R; li/lui/addi/andi/ori → EXEC_I; b/beq/bne → BRANCH; loads/stores → MEM_ADDR; any other opcode → FETCH (executed as nop).
  - EXEC_R: `ALU_Bin_sel`=0, `ALU_func`=func → WB_ALU.
  - EXEC_I: `ALU_Bin_sel`=1. `ImmExt` = 01 for li/addi, 00 for andi/ori, 10 for lui. lui uses `ALU_func`=or with rs=R0 → WB_ALU.
  - BRANCH: `RF_B_sel`=1, `ALU_Bin_sel`=0, `ALU_func`=sub, `ImmExt`=11, `PC_sel`=1. `PC_LdEn` = b | (beq & `ALU_zero`) | (bne & !`ALU_zero`) → FETCH.
  - MEM_ADDR: `ALU_Bin_sel`=1, `ImmExt`=01, add, `RF_B_sel`=1 → MEM_RD for loads, MEM_WR for stores.
  - MEM_RD: read cycle, `ByteOp` per opcode → WB_MEM.
  - MEM_WR: `MEM_WrEn`=1, `ByteOp` per opcode → FETCH.
  - WB_ALU: `RF_WrEn`=1, `RF_WrData_sel`=0 → FETCH.
  - WB_MEM: `RF_WrEn`=1, `RF_WrData_sel`=1 → FETCH.
- At most one of `RF_WrEn`, `MEM_WrEn`, `Instr_LdEn` is high in any cycle.

## Timing
- Reset values: state = RESET_IDLE; all outputs 0, including `ALU_func`=0000, `ImmExt`=00, `PC_sel`=0.
- RESET_IDLE → FETCH on the first edge with `Reset` low, so no write occurs in the cycle after `Reset` deasserts.
- Reset asserted in any state, including mid-MEM_WR or WB: the next edge returns to RESET_IDLE. Pending writes are dropped; outputs are 0 from that edge on.
- Cycles per instruction:
  - R-type / I-type: 4
  - branch: 3, taken or not
  - store: 4
  - load: 5
- `ALU_zero` is sampled only in BRANCH, in the same cycle as the sub.
- `Instr` is ignored in FETCH; decode uses the value present in DECODE.

## Structure
- Package `control_pkg`: opcode localparams, ALU_func codes, ImmExt codes, state encoding (4-bit).
- Sub-module `instr_decoder`: combinational opcode → class (R, I_ALU, BR, LD, ST, ILLEGAL) plus per-op `ImmExt`/`ALU_func`/`ByteOp`. The FSM consumes only the class and these fields.

## Test plan
- Reset held 3 cycles, then released with `Instr`=R-type add → all outputs 0 during reset; FETCH, DECODE, EXEC_R (`ALU_func`=0000), WB_ALU (`RF_WrEn`=1), FETCH; 4 cycles.
- Each R-type func 0000/0001/0010/0011/0100/1000/1001/1010/1100/1101 → same value on `ALU_func` in EXEC_R with `ALU_Bin_sel`=0.
- beq with `ALU_zero`=1 → `PC_LdEn`=1, `PC_sel`=1, `ImmExt`=11 in BRANCH. Same with `ALU_zero`=0 → `PC_LdEn`=0. bne gives the inverse.
- lb then sw:
  - lb: 5 cycles, `ByteOp`=1 in MEM_RD, `RF_WrData_sel`=1 with `RF_WrEn`=1 in WB_MEM.
  - sw: `MEM_WrEn`=1, `ByteOp`=0 for exactly one cycle.
- Opcode `101010` → DECODE then FETCH, no write enables asserted.
- `Reset` asserted during MEM_WR → `MEM_WrEn` 0 from the next edge; restart from RESET_IDLE → FETCH.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU/immediate codes,
// FSM state encoding and the per-state output table.
package control_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOTA = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_ROL  = 4'b1100;
    localparam logic [3:0] ALU_ROR  = 4'b1101;

    localparam logic [1:0] IMM_ZERO     = 2'b00;
    localparam logic [1:0] IMM_SIGN     = 2'b01;
    localparam logic [1:0] IMM_HIGH     = 2'b10;
    localparam logic [1:0] IMM_BR_SHIFT = 2'b11;

    typedef enum logic [3:0] {
        ST_RESET_IDLE = 4'd0,
        ST_FETCH      = 4'd1,
        ST_DECODE     = 4'd2,
        ST_EXEC_R     = 4'd3,
        ST_EXEC_I     = 4'd4,
        ST_BRANCH     = 4'd5,
        ST_MEM_ADDR   = 4'd6,
        ST_MEM_RD     = 4'd7,
        ST_MEM_WR     = 4'd8,
        ST_WB_ALU     = 4'd9,
        ST_WB_MEM     = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CLASS_R       = 3'd0,
        CLASS_I_ALU   = 3'd1,
        CLASS_BR      = 3'd2,
        CLASS_LD      = 3'd3,
        CLASS_ST      = 3'd4,
        CLASS_ILLEGAL = 3'd5
    } instr_class_t;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'd0,
        BR_EQ     = 2'd1,
        BR_NE     = 2'd2,
        BR_NONE   = 2'd3
    } br_kind_t;

    typedef struct packed {
        instr_class_t op_class;
        logic [1:0]   imm_ext;
        logic [3:0]   alu_func;
        logic         byte_op;
        br_kind_t     br_kind;
    } decode_t;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_ld_en;
        logic       instr_ld_en;
        logic       rf_wr_en;
        logic       rf_wr_data_sel;
        logic       rf_b_sel;
        logic [1:0] imm_ext;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_wr_en;
        logic       byte_op;
    } ctrl_t;

    function automatic state_t next_state(state_t s, decode_t d);
        state_t n;
        n = ST_FETCH;
        case (s)
            ST_RESET_IDLE: n = ST_FETCH;
            ST_FETCH:      n = ST_DECODE;
            ST_DECODE: begin
                case (d.op_class)
                    CLASS_R:     n = ST_EXEC_R;
                    CLASS_I_ALU: n = ST_EXEC_I;
                    CLASS_BR:    n = ST_BRANCH;
                    CLASS_LD,
                    CLASS_ST:    n = ST_MEM_ADDR;
                    default:     n = ST_FETCH;
                endcase
            end
            ST_EXEC_R,
            ST_EXEC_I:     n = ST_WB_ALU;
            ST_MEM_ADDR:   n = (d.op_class == CLASS_LD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:     n = ST_WB_MEM;
            default:       n = ST_FETCH;
        endcase
        return n;
    endfunction

    // Output pattern held for a whole state; the branch PC enable is added in the top
    // because it depends on ALU_zero within the BRANCH cycle itself.
    function automatic ctrl_t state_outputs(state_t s, decode_t d);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.instr_ld_en = 1'b1;
                c.pc_ld_en    = 1'b1;
            end
            ST_EXEC_R: c.alu_func = d.alu_func;
            ST_EXEC_I: begin
                c.alu_bin_sel = 1'b1;
                c.imm_ext     = d.imm_ext;
                c.alu_func    = d.alu_func;
            end
            ST_BRANCH: begin
                c.rf_b_sel = 1'b1;
                c.alu_func = ALU_SUB;
                c.imm_ext  = IMM_BR_SHIFT;
                c.pc_sel   = 1'b1;
            end
            ST_MEM_ADDR: begin
                c.alu_bin_sel = 1'b1;
                c.imm_ext     = IMM_SIGN;
                c.alu_func    = ALU_ADD;
                c.rf_b_sel    = 1'b1;
            end
            ST_MEM_RD: c.byte_op = d.byte_op;
            ST_MEM_WR: begin
                c.mem_wr_en = 1'b1;
                c.byte_op   = d.byte_op;
            end
            ST_WB_ALU: c.rf_wr_en = 1'b1;
            ST_WB_MEM: begin
                c.rf_wr_en       = 1'b1;
                c.rf_wr_data_sel = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into an instruction class plus the per-op
// immediate mode, ALU function, byte-access flag and branch condition.
module instr_decoder
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [3:0] func,
    output decode_t    dec
);

    always_comb begin
        dec.op_class = CLASS_ILLEGAL;
        dec.imm_ext  = IMM_ZERO;
        dec.alu_func = ALU_ADD;
        dec.byte_op  = 1'b0;
        dec.br_kind  = BR_NONE;
        case (opcode)
            OP_RTYPE: begin
                dec.op_class = CLASS_R;
                dec.alu_func = func;
            end
            OP_LI, OP_ADDI: begin
                dec.op_class = CLASS_I_ALU;
                dec.imm_ext  = IMM_SIGN;
            end
            // lui relies on rs = R0, so OR-ing the shifted immediate just passes it through
            OP_LUI: begin
                dec.op_class = CLASS_I_ALU;
                dec.imm_ext  = IMM_HIGH;
                dec.alu_func = ALU_OR;
            end
            OP_ANDI: begin
                dec.op_class = CLASS_I_ALU;
                dec.alu_func = ALU_AND;
            end
            OP_ORI: begin
                dec.op_class = CLASS_I_ALU;
                dec.alu_func = ALU_OR;
            end
            OP_B: begin
                dec.op_class = CLASS_BR;
                dec.imm_ext  = IMM_BR_SHIFT;
                dec.alu_func = ALU_SUB;
                dec.br_kind  = BR_ALWAYS;
            end
            OP_BEQ: begin
                dec.op_class = CLASS_BR;
                dec.imm_ext  = IMM_BR_SHIFT;
                dec.alu_func = ALU_SUB;
                dec.br_kind  = BR_EQ;
            end
            OP_BNE: begin
                dec.op_class = CLASS_BR;
                dec.imm_ext  = IMM_BR_SHIFT;
                dec.alu_func = ALU_SUB;
                dec.br_kind  = BR_NE;
            end
            OP_LB: begin
                dec.op_class = CLASS_LD;
                dec.imm_ext  = IMM_SIGN;
                dec.byte_op  = 1'b1;
            end
            OP_LW: begin
                dec.op_class = CLASS_LD;
                dec.imm_ext  = IMM_SIGN;
            end
            OP_SB: begin
                dec.op_class = CLASS_ST;
                dec.imm_ext  = IMM_SIGN;
                dec.byte_op  = 1'b1;
            end
            OP_SW: begin
                dec.op_class = CLASS_ST;
                dec.imm_ext  = IMM_SIGN;
            end
            default: dec.op_class = CLASS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// registered datapath controls from the next state and the latched decode.
module multicycle_control
    import control_pkg::*;
#(
    parameter int DATA_W = control_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Instr,
    input  logic              ALU_zero,
    output logic              PC_sel,
    output logic              PC_LdEn,
    output logic              Instr_LdEn,
    output logic              RF_WrEn,
    output logic              RF_WrData_sel,
    output logic              RF_B_sel,
    output logic [1:0]        ImmExt,
    output logic              ALU_Bin_sel,
    output logic [3:0]        ALU_func,
    output logic              MEM_WrEn,
    output logic              ByteOp
);

    state_t  state;
    ctrl_t   ctrl_q;
    decode_t dec_live;
    decode_t dec_q;
    decode_t dec_sel;
    logic    branch_taken;
    logic    unused_instr_bits;

    assign unused_instr_bits = ^Instr[DATA_W-7:4];

    instr_decoder u_decoder (
        .opcode (Instr[DATA_W-1:DATA_W-6]),
        .func   (Instr[3:0]),
        .dec    (dec_live)
    );

    // Leaving DECODE uses the live decode; every later state uses the copy latched then.
    assign dec_sel = (state == ST_DECODE) ? dec_live : dec_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_RESET_IDLE;
            ctrl_q <= '0;
            dec_q  <= '0;
        end else begin
            state  <= next_state(state, dec_sel);
            ctrl_q <= state_outputs(next_state(state, dec_sel), dec_sel);
            if (state == ST_DECODE) begin
                dec_q <= dec_live;
            end
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        if (state == ST_BRANCH) begin
            case (dec_q.br_kind)
                BR_ALWAYS: branch_taken = 1'b1;
                BR_EQ:     branch_taken = ALU_zero;
                BR_NE:     branch_taken = ~ALU_zero;
                default:   branch_taken = 1'b0;
            endcase
        end
    end

    assign PC_sel        = ctrl_q.pc_sel;
    assign PC_LdEn       = ctrl_q.pc_ld_en | branch_taken;
    assign Instr_LdEn    = ctrl_q.instr_ld_en;
    assign RF_WrEn       = ctrl_q.rf_wr_en;
    assign RF_WrData_sel = ctrl_q.rf_wr_data_sel;
    assign RF_B_sel      = ctrl_q.rf_b_sel;
    assign ImmExt        = ctrl_q.imm_ext;
    assign ALU_Bin_sel   = ctrl_q.alu_bin_sel;
    assign ALU_func      = ctrl_q.alu_func;
    assign MEM_WrEn      = ctrl_q.mem_wr_en;
    assign ByteOp        = ctrl_q.byte_op;

endmodule
